// File: rtl/rr_dispatch4.sv
// Round-robin dispatcher: streams upstream beats to one of four consumers in bursts.
// The consumer is chosen by rotating priority, and the payload passes through combinationally.
module rr_dispatch4 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [3:0]       beat_cnt
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] LastBeat = 4'(BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       req_sel;
  logic       xfer;

  // Priority starts just after the previous winner, so the previous winner comes last.
  always_comb begin
    winner = last_q;
    idx    = last_q;
    found  = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign req_sel = req[sel_q];

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    busy       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 4'b0000;
    xfer       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StBusy;
          sel_d      = winner;
          last_d     = winner;
          beat_cnt_d = 4'd0;
        end
      end
      StBusy: begin
        busy             = 1'b1;
        in_ready         = req_sel;
        xfer             = in_valid & req_sel;
        out_valid[sel_q] = xfer;
        if (!req_sel) begin
          // The granted consumer withdrew its request: the grant ends without a transfer.
          state_d    = StIdle;
          beat_cnt_d = 4'd0;
        end else if (xfer) begin
          if (beat_cnt_q == LastBeat) begin
            state_d    = StIdle;
            beat_cnt_d = 4'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= 2'b00;
      last_q     <= 2'b11;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign out_data = in_data;
  assign sel      = sel_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: doc/rr_dispatch4.md
RR_DISPATCH4 -- requirements
Module: rr_dispatch4

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits.
REQ-002 Parameter BURST, default 4, max beats per grant; legal range 1..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-consumer request; bit i = consumer i wants data.
REQ-006 in_valid  input  1  upstream beat available.
REQ-007 in_data  input  WIDTH  upstream beat payload.
REQ-008 in_ready  output  1  upstream beat accepted this cycle when high with in_valid.
REQ-009 out_valid  output  4  one-hot beat strobe to the granted consumer.
REQ-010 out_data  output  WIDTH  payload broadcast to all consumers.
REQ-011 sel  output  2  index of current or most recent grant; drives the 1-to-4 demux select.
REQ-012 busy  output  1  high while a grant is held.
REQ-013 beat_cnt  output  4  beats transferred in the current grant.

Function
REQ-014 FSM has two states, IDLE and BUSY; state, sel, last-grant pointer and beat_cnt are registered.
REQ-015 IDLE: busy=0, in_ready=0, out_valid=0000.
REQ-016 IDLE with req!=0: winner = first set bit of req scanning last+1, last+2, last+3, last (mod 4); next edge: sel=winner, last=winner, beat_cnt=0, state=BUSY.
REQ-017 IDLE with req==0: state, sel, last, beat_cnt hold.
REQ-018 Grant latency: exactly one cycle from req sampled in IDLE to busy=1.
REQ-019 BUSY: busy=1; in_ready = req[sel]; out_valid[sel] = in_valid & req[sel], other bits 0; all combinational.
REQ-020 out_data = in_data combinationally in every state; no data register, zero-cycle data latency.
REQ-021 Transfer = in_valid & in_ready; each transfer increments beat_cnt by 1 at the edge.
REQ-022 BUSY exits to IDLE on the edge where a transfer occurs with beat_cnt==BURST-1; beat_cnt is then cleared to 0.
REQ-023 BUSY exits to IDLE on the edge after any cycle with req[sel]==0; no transfer occurs in that cycle; beat_cnt cleared to 0.
REQ-024 BUSY with req[sel]=1 and in_valid=0: hold state and beat_cnt (upstream stall).
REQ-025 Requests from non-granted consumers are ignored while BUSY; no preemption.
REQ-026 At least one IDLE cycle separates consecutive grants, including back-to-back grants to the same consumer.
REQ-027 A sole requester that keeps req high is re-granted after the IDLE cycle (no starvation of a sole requester).
REQ-028 With all four requesting continuously, grants rotate 0,1,2,3,0... from reset.
REQ-029 sel holds its last value in IDLE; it changes only on a grant edge.

Reset
REQ-030 rst high forces immediately, regardless of clk: state=IDLE, sel=00, last=11, beat_cnt=0, busy=0, in_ready=0, out_valid=0000.
REQ-031 Reset asserted mid-burst abandons the burst; no transfer is reported while rst is high.
REQ-032 First arbitration after reset gives consumer 0 highest priority.

Verification
REQ-033 Reset, then req=1111 held, in_valid=1 constant, BURST=4 -> grants to 0,1,2,3,0 in order; each grant has 4 out_valid pulses; 1 idle cycle between grants.
REQ-034 Only req[2] held, in_valid=1 -> busy pattern 0,1,1,1,1,0,1,...; sel=10 throughout; out_valid=0100 during each burst.
REQ-035 Grant to 1; in_valid toggles 1,0,1,0... -> beat_cnt advances only on in_valid=1 cycles; exit after the 4th beat; in_ready stays 1 throughout.
REQ-036 Grant to 3; drop req[3] after 2 beats -> in_ready=0 that cycle; IDLE next edge; beat_cnt=0; next winner scans from 0.
REQ-037 Assert rst mid-burst at beat_cnt=2 -> outputs reach reset values without a clock edge; after release, req=0110 grants 1 first.
REQ-038 in_data=16'hA5A5 while busy with sel=01 -> out_data=A5A5 in the same cycle; out_valid=0010.
